// File: rtl/parser_layer_lookup.sv
// Per-layer rule lookup: type match and key-field extraction, aligned to the delayed start slice.
// Fixed 3-cycle latency for every slice; no backpressure, accepts one slice per cycle.
module parser_layer_lookup #(
  parameter int HEAD_WIDTH       = 512,
  parameter int META_WIDTH       = 1024,
  parameter int TAG_WIDTH        = 8,
  parameter int SHIFT_WIDTH      = 16,
  parameter int HEAD_SHIFT_WIDTH = 5,
  parameter int META_SHIFT_WIDTH = 4,
  parameter int KEY_FILED_NUM    = 8,
  parameter int KEY_FIELD_WIDTH  = 16,
  parameter int TYPE_WIDTH       = 16,
  parameter int RULE_NUM         = 8,
  parameter int RULE_WIDTH       = 1 + 2*TYPE_WIDTH + HEAD_SHIFT_WIDTH + META_SHIFT_WIDTH
                                   + KEY_FILED_NUM*(HEAD_SHIFT_WIDTH+1)
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic [HEAD_WIDTH+TAG_WIDTH-1:0]          i_head,
  input  logic [META_WIDTH+TAG_WIDTH-1:0]          i_meta,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0]          o_head,
  output logic [META_WIDTH+TAG_WIDTH-1:0]          o_meta,
  output logic [HEAD_SHIFT_WIDTH-1:0]              o_headShift,
  output logic [META_SHIFT_WIDTH-1:0]              o_metaShift,
  output logic [KEY_FILED_NUM*KEY_FIELD_WIDTH-1:0] o_extField,
  input  logic                                     i_rule_wren,
  input  logic [$clog2(RULE_NUM+1)-1:0]            i_rule_addr,
  input  logic [RULE_WIDTH-1:0]                    i_rule_wdata
);

  localparam int HW            = HEAD_WIDTH + TAG_WIDTH;
  localparam int MW            = META_WIDTH + TAG_WIDTH;
  localparam int AW            = $clog2(RULE_NUM + 1);
  localparam int KN            = KEY_FILED_NUM;
  localparam int TAG_START_BIT = 0;
  localparam int TAG_VALID_BIT = 1;

  // Field order (MSB first) mirrors the config write word.
  typedef struct packed {
    logic                                  vld;
    logic [TYPE_WIDTH-1:0]                 type_val;
    logic [TYPE_WIDTH-1:0]                 type_msk;
    logic [HEAD_SHIFT_WIDTH-1:0]           head_shift;
    logic [META_SHIFT_WIDTH-1:0]           meta_shift;
    logic [KN-1:0]                         field_en;
    logic [KN-1:0][HEAD_SHIFT_WIDTH-1:0]   off;
  } rule_t;

  typedef struct packed {
    logic [HEAD_SHIFT_WIDTH-1:0]           head_shift;
    logic [META_SHIFT_WIDTH-1:0]           meta_shift;
    logic [KN-1:0]                         field_en;
    logic [KN-1:0][HEAD_SHIFT_WIDTH-1:0]   off;
  } snap_t;

  function automatic logic is_start(input logic [HW-1:0] s);
    return s[HEAD_WIDTH+TAG_VALID_BIT] & s[HEAD_WIDTH+TAG_START_BIT];
  endfunction

  // Offset k addresses granule k counted from the MSB end of the slice.
  function automatic logic [TYPE_WIDTH-1:0] get_type(input logic [HEAD_WIDTH-1:0] d,
                                                     input logic [HEAD_SHIFT_WIDTH-1:0] k);
    return TYPE_WIDTH'(d >> (HEAD_WIDTH - TYPE_WIDTH - int'(k) * SHIFT_WIDTH));
  endfunction

  function automatic logic [KEY_FIELD_WIDTH-1:0] get_key(input logic [HEAD_WIDTH-1:0] d,
                                                         input logic [HEAD_SHIFT_WIDTH-1:0] k);
    return KEY_FIELD_WIDTH'(d >> (HEAD_WIDTH - KEY_FIELD_WIDTH - int'(k) * SHIFT_WIDTH));
  endfunction

  rule_t                               rule_q [RULE_NUM];
  logic [HEAD_SHIFT_WIDTH-1:0]         typeoff_q;
  logic [HW-1:0]                       head1_q, head2_q, head3_q;
  logic [MW-1:0]                       meta1_q, meta2_q, meta3_q;
  logic [TYPE_WIDTH-1:0]               type_q, type_d;
  snap_t                               snap_q, snap_d;
  logic [HEAD_SHIFT_WIDTH-1:0]         hshift_q;
  logic [META_SHIFT_WIDTH-1:0]         mshift_q;
  logic [KN-1:0][KEY_FIELD_WIDTH-1:0]  ext_q, ext_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RULE_NUM; i++) rule_q[i] <= '0;
      typeoff_q <= '0;
    end else if (i_rule_wren) begin
      for (int i = 0; i < RULE_NUM; i++)
        if (i_rule_addr == AW'(i)) rule_q[i] <= rule_t'(i_rule_wdata);
      if (i_rule_addr == AW'(RULE_NUM)) typeoff_q <= i_rule_wdata[HEAD_SHIFT_WIDTH-1:0];
    end
  end

  always_comb begin
    type_d = get_type(i_head[HEAD_WIDTH-1:0], typeoff_q);
  end

  // Match reads the table before this edge's write lands, so a same-cycle rewrite is not seen.
  always_comb begin
    snap_d = '0;
    for (int i = RULE_NUM - 1; i >= 0; i--) begin
      if (rule_q[i].vld &&
          ((type_q & rule_q[i].type_msk) == (rule_q[i].type_val & rule_q[i].type_msk))) begin
        snap_d.head_shift = rule_q[i].head_shift;
        snap_d.meta_shift = rule_q[i].meta_shift;
        snap_d.field_en   = rule_q[i].field_en;
        snap_d.off        = rule_q[i].off;
      end
    end
  end

  always_comb begin
    ext_d = '0;
    for (int j = 0; j < KN; j++) begin
      if (snap_q.field_en[KN-1-j])
        ext_d[KN-1-j] = get_key(head2_q[HEAD_WIDTH-1:0], snap_q.off[KN-1-j]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head1_q  <= '0;
      head2_q  <= '0;
      head3_q  <= '0;
      meta1_q  <= '0;
      meta2_q  <= '0;
      meta3_q  <= '0;
      type_q   <= '0;
      snap_q   <= '0;
      hshift_q <= '0;
      mshift_q <= '0;
      ext_q    <= '0;
    end else begin
      head1_q <= i_head;
      head2_q <= head1_q;
      head3_q <= head2_q;
      meta1_q <= i_meta;
      meta2_q <= meta1_q;
      meta3_q <= meta2_q;
      if (is_start(i_head))  type_q <= type_d;
      if (is_start(head1_q)) snap_q <= snap_d;
      if (is_start(head2_q)) begin
        hshift_q <= snap_q.head_shift;
        mshift_q <= snap_q.meta_shift;
        ext_q    <= ext_d;
      end
    end
  end

  assign o_head      = head3_q;
  assign o_meta      = meta3_q;
  assign o_headShift = hshift_q;
  assign o_metaShift = mshift_q;
  assign o_extField  = ext_q;

endmodule
